// File: rtl/puf_response_collector_if.sv
// ---------------------------------------------------------------------------
// puf_response_collector_if
// Host-side bundle of the PUF response collector.
//   start        : pulse, begins a collection when the collector is idle
//   seed         : 8-bit LFSR seed, captured with an accepted start
//   resp_valid   : response word available
//   resp_ready   : host accepts the response word
//   resp_data    : voted response bits (bit n from challenge n)
//   unstable_cnt : number of bits whose votes were not unanimous
//   busy         : collector is not idle
// master = host, slave = collector.
// ---------------------------------------------------------------------------
interface puf_response_collector_if;
    logic        start;
    logic [7:0]  seed;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [5:0]  unstable_cnt;
    logic        busy;

    modport master (
        output start, seed, resp_ready,
        input  resp_valid, resp_data, unstable_cnt, busy
    );

    modport slave (
        input  start, seed, resp_ready,
        output resp_valid, resp_data, unstable_cnt, busy
    );
endinterface

// File: rtl/puf_response_collector.sv
// ---------------------------------------------------------------------------
// puf_response_collector
// Drives a DelayPUF through reset/run/sample cycles, majority-votes VOTES
// evaluations per challenge and packs RESP_BITS voted bits into a response
// word handed to the host over a valid/ready handshake. Challenges come from
// an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded by the host.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   host          : host bundle (start/seed in, response handshake out, busy)
//   puf_reset     : to PUF reset
//   puf_run       : to PUF a_run
//   puf_challenge : to PUF a_challenge (current LFSR state)
//   puf_result    : from PUF result, asynchronous to clk
// ---------------------------------------------------------------------------
module puf_response_collector #(
    parameter int RESP_BITS     = 32,
    parameter int VOTES         = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    puf_response_collector_if.slave  host,
    output logic                     puf_reset,
    output logic                     puf_run,
    output logic [7:0]               puf_challenge,
    input  logic                     puf_result
);

    localparam int SW = $clog2(SETTLE_CYCLES);

    typedef enum logic [2:0] {IDLE, PRST, PRUN, PSAMP, DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic [7:0]      r_lfsr;
    logic [SW-1:0]   r_settle;
    logic [3:0]      r_vote;
    logic [3:0]      r_ones;
    logic [4:0]      r_bit;
    logic [31:0]     r_data;
    logic [5:0]      r_unstable;

    logic            w_settled;
    logic            w_last_vote;
    logic            w_last_bit;
    logic [3:0]      w_ones_sum;
    logic            w_voted;
    logic            w_unstable;
    logic [7:0]      w_lfsr_nxt;

    assign w_settled   = (r_settle == SW'(SETTLE_CYCLES - 1));
    assign w_last_vote = (r_vote == 4'(VOTES - 1));
    assign w_last_bit  = (r_bit == 5'(RESP_BITS - 1));
    // Ones counter including the vote being sampled in this PSAMP cycle.
    assign w_ones_sum  = r_ones + {3'b000, r_sync2};
    assign w_voted     = (w_ones_sum > 4'(VOTES / 2));
    assign w_unstable  = (w_ones_sum != 4'd0) && (w_ones_sum != 4'(VOTES));
    assign w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    assign puf_challenge     = r_lfsr;
    assign host.resp_data    = r_data;
    assign host.unstable_cnt = r_unstable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        puf_reset       = 1'b1;
        puf_run         = 1'b0;
        host.resp_valid = 1'b0;
        host.busy       = 1'b1;
        case (r_state)
            IDLE: begin
                host.busy = 1'b0;
                if (host.start) w_state_nxt = PRST;
            end
            PRST: begin
                w_state_nxt = PRUN;
            end
            PRUN: begin
                puf_reset = 1'b0;
                puf_run   = 1'b1;
                if (w_settled) w_state_nxt = PSAMP;
            end
            PSAMP: begin
                puf_reset = 1'b0;
                if (w_last_vote && w_last_bit) w_state_nxt = DONE;
                else                           w_state_nxt = PRST;
            end
            DONE: begin
                host.resp_valid = 1'b1;
                // A start coinciding with the handshake is not seen here.
                if (host.resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The PUF result is asynchronous; the two-flop delay is hidden inside
    // the settle window, so PSAMP always sees a settled value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= puf_result;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr     <= 8'h00;
            r_settle   <= '0;
            r_vote     <= 4'd0;
            r_ones     <= 4'd0;
            r_bit      <= 5'd0;
            r_data     <= 32'd0;
            r_unstable <= 6'd0;
        end else begin
            r_settle <= (r_state == PRUN) ? r_settle + SW'(1) : '0;
            case (r_state)
                IDLE: begin
                    if (host.start) begin
                        // An all-zero state would lock the LFSR.
                        r_lfsr     <= (host.seed == 8'h00) ? 8'h01 : host.seed;
                        r_vote     <= 4'd0;
                        r_ones     <= 4'd0;
                        r_bit      <= 5'd0;
                        r_data     <= 32'd0;
                        r_unstable <= 6'd0;
                    end
                end
                PSAMP: begin
                    if (!w_last_vote) begin
                        r_vote <= r_vote + 4'd1;
                        r_ones <= w_ones_sum;
                    end else begin
                        r_data[r_bit] <= w_voted;
                        r_unstable    <= r_unstable + {5'd0, w_unstable};
                        r_ones        <= 4'd0;
                        r_vote        <= 4'd0;
                        r_lfsr        <= w_lfsr_nxt;
                        if (!w_last_bit) r_bit <= r_bit + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  u;
        int          vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mode = 0;
    int   ev_cnt = 0;
    logic prev_run = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    puf_response_collector_if h ();
    puf_response_collector_if h2 ();

    logic       p_reset, p_run, p_res;
    logic [7:0] p_ch;
    logic       p2_reset, p2_run;
    logic [7:0] p2_ch;
    logic       p2_res;
    assign p2_res = 1'b1;

    puf_response_collector dut (
        .clk(clk), .reset_n(reset_n), .host(h),
        .puf_reset(p_reset), .puf_run(p_run),
        .puf_challenge(p_ch), .puf_result(p_res)
    );

    puf_response_collector #(.RESP_BITS(4), .VOTES(1), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .host(h2),
        .puf_reset(p2_reset), .puf_run(p2_run),
        .puf_challenge(p2_ch), .puf_result(p2_res)
    );

    // PUF behaviour model: evaluation index advances once run drops.
    always @(negedge clk) begin
        prev_run <= p_run;
        if (!h.busy)                 ev_cnt <= 0;
        else if (prev_run && !p_run) ev_cnt <= ev_cnt + 1;
    end

    always_comb begin
        case (mode)
            1:       p_res = p_ch[0];
            2:       p_res = ((ev_cnt % 3) != 1);
            3:       p_res = ((ev_cnt % 3) == 1);
            default: p_res = 1'b1;
        endcase
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    function automatic exp_t model(input int md, input logic [7:0] sd,
                                   input int rb, input int nv, input int st);
        exp_t e;
        logic [7:0] c;
        int ones;
        int ev;
        logic b;
        c = (sd == 8'h00) ? 8'h01 : sd;
        e.d = 32'd0;
        e.u = 6'd0;
        for (int n = 0; n < rb; n++) begin
            ones = 0;
            for (int v = 0; v < nv; v++) begin
                ev = n * nv + v;
                case (md)
                    1:       b = c[0];
                    2:       b = ((ev % 3) != 1);
                    3:       b = ((ev % 3) == 1);
                    default: b = 1'b1;
                endcase
                ones += int'(b);
            end
            e.d[n] = (2 * ones > nv);
            if (ones != 0 && ones != nv) e.u = e.u + 6'd1;
            c = lfsr_step(c);
        end
        e.vcyc = rb * nv * (st + 2);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_puf_reset"}, 64'(p_reset), 64'd1);
        check({tag, "_puf_run"}, 64'(p_run), 64'd0);
        check({tag, "_challenge"}, 64'(p_ch), 64'd0);
        check({tag, "_valid"}, 64'(h.resp_valid), 64'd0);
        check({tag, "_data"}, 64'(h.resp_data), 64'd0);
        check({tag, "_unstable"}, 64'(h.unstable_cnt), 64'd0);
        check({tag, "_busy"}, 64'(h.busy), 64'd0);
    endtask

    task automatic start_run(input logic [7:0] sd, input int md, input bit push, output int kp1);
        exp_t e;
        @(negedge clk);
        mode = md;
        h.seed = sd;
        h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        kp1 = cyc;
        check("busy_after_start", 64'(h.busy), 64'd1);
        if (push) begin
            e = model(md, sd, 32, 3, 16);
            e.vcyc = e.vcyc + kp1;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input int hold);
        int n;
        bit stable;
        exp_t e;
        logic [31:0] d0;
        logic [5:0] u0;
        n = 0;
        while (!h.resp_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 64'(h.resp_valid), 64'd1);
        if (!h.resp_valid || sb.size() == 0) return;
        e = sb.pop_front();
        check("valid_cycle", 64'(cyc), 64'(e.vcyc));
        check("resp_data", 64'(h.resp_data), 64'(e.d));
        check("unstable_cnt", 64'(h.unstable_cnt), 64'(e.u));
        if (hold > 0) begin
            d0 = h.resp_data;
            u0 = h.unstable_cnt;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                h.start = (i == 50);
                @(negedge clk);
                if (!h.resp_valid || h.resp_data !== d0 || h.unstable_cnt !== u0) stable = 1'b0;
            end
            check("bp_stable", 64'(stable), 64'd1);
            check("bp_busy", 64'(h.busy), 64'd1);
        end
        h.resp_ready = 1'b1;
        h.start = (hold > 0);
        @(negedge clk);
        h.resp_ready = 1'b0;
        h.start = 1'b0;
        check("hs_busy", 64'(h.busy), 64'd0);
        check("hs_valid", 64'(h.resp_valid), 64'd0);
        if (hold > 0) begin
            repeat (30) @(negedge clk);
            check("start_dropped_busy", 64'(h.busy), 64'd0);
        end
    endtask

    initial begin
        int kp1;
        int n;
        bit saw_valid;
        exp_t e2;

        reset_n = 1'b0;
        h.start = 1'b0;
        h.seed = 8'h00;
        h.resp_ready = 1'b0;
        h2.start = 1'b0;
        h2.seed = 8'h00;
        h2.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Constant 1, seed 0x5A: challenge sequence and all-ones word.
        start_run(8'h5A, 0, 1'b1, kp1);
        check("first_challenge", 64'(p_ch), 64'h5A);
        n = 0;
        while (p_ch == 8'h5A && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("second_challenge", 64'(p_ch), 64'hB4);
        check("challenge_change_cycle", 64'(cyc), 64'(kp1 + 54));
        collect(0);

        // Result follows challenge bit 0, seed 0 fixed up to 0x01.
        start_run(8'h00, 1, 1'b1, kp1);
        check("seed0_challenge", 64'(p_ch), 64'h01);
        collect(0);

        // Non-unanimous votes 1,0,1 then 0,1,0 (latter with backpressure).
        start_run(8'h33, 2, 1'b1, kp1);
        collect(0);
        start_run(8'hA7, 3, 1'b1, kp1);
        collect(100);

        // Asynchronous reset mid-collection discards it.
        start_run(8'hC3, 0, 1'b0, kp1);
        n = 0;
        while (cyc < kp1 + 499 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("held_rst");
        reset_n = 1'b1;
        saw_valid = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (h.resp_valid) saw_valid = 1'b1;
        end
        check("no_valid_after_rst", 64'(saw_valid), 64'd0);
        check("idle_after_rst", 64'(h.busy), 64'd0);

        // Small configuration: 4 bits, 1 vote, 3 settle cycles.
        @(negedge clk);
        h2.seed = 8'h21;
        h2.start = 1'b1;
        @(negedge clk);
        h2.start = 1'b0;
        kp1 = cyc;
        e2 = model(0, 8'h21, 4, 1, 3);
        e2.vcyc = e2.vcyc + kp1;
        sb.push_back(e2);
        n = 0;
        while (!h2.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("small_valid_seen", 64'(h2.resp_valid), 64'd1);
        if (h2.resp_valid) begin
            e2 = sb.pop_front();
            check("small_valid_cycle", 64'(cyc), 64'(e2.vcyc));
            check("small_resp_data", 64'(h2.resp_data), 64'(e2.d));
            check("small_unstable", 64'(h2.unstable_cnt), 64'(e2.u));
            h2.resp_ready = 1'b1;
            @(negedge clk);
            h2.resp_ready = 1'b0;
            check("small_hs_busy", 64'(h2.busy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
